// File: rtl/axi_pwm_multi.sv
// axi_pwm_multi
//   AXI4-Lite slave driving NUM_CH PWM outputs from one shared period counter.
//   Software writes PERIOD and DUTY[i] into shadow registers. The active copies
//   reload only on counter wrap (or continuously while stopped), so a waveform
//   never changes shape part-way through a period.
//
//   Optional feature: define AXI_PWM_IRQ_EN to build the period-wrap interrupt
//   (IRQ_STATUS at 0x0C, W1C; IRQ_EN at 0x10). Without it, irq is tied low and
//   those two addresses read 0 and ignore writes.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*          : AXI4-Lite write channel (bresp always OKAY)
//   s00_axi_ar* / r*               : AXI4-Lite read channel (rresp always OKAY)
//   PWM_OUT[NUM_CH-1:0]            : registered PWM outputs
//   irq                            : registered level interrupt, active-high
//
// Register map (byte address)
//   0x00 CTRL[0]=RUN   0x04 CH_EN   0x08 PERIOD   0x0C IRQ_STATUS   0x10 IRQ_EN
//   0x14 CNT (ro)      0x20+4*i DUTY[i]
module axi_pwm_multi #(
    parameter int NUM_CH             = 8,
    parameter int CNT_WIDTH          = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic [NUM_CH-1:0]             PWM_OUT,
    output logic                          irq
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] A_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] A_CH_EN  = IDX_W'(1);
    localparam logic [IDX_W-1:0] A_PERIOD = IDX_W'(2);
    localparam logic [IDX_W-1:0] A_CNT    = IDX_W'(5);
`ifdef AXI_PWM_IRQ_EN
    localparam logic [IDX_W-1:0] A_STAT   = IDX_W'(3);
    localparam logic [IDX_W-1:0] A_IRQEN  = IDX_W'(4);
`endif

    logic                 awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0]          rdata_q, rd_mux, wmask;
    logic                 wr_accept, rd_accept, wrap;
    logic [IDX_W-1:0]     wr_idx, rd_idx;
    logic                 run;
    logic [NUM_CH-1:0]    ch_en, pwm_next, pwm_p1;
    logic [CNT_WIDTH-1:0] period_sh, period_act, cnt_p0;
    logic [CNT_WIDTH-1:0] duty_sh  [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act [NUM_CH];
    logic                 unused_ok;

    // Byte-strobe merge: strobed bytes take new data, the rest keep old bits.
    function automatic logic [CNT_WIDTH-1:0] merge_cnt(input logic [CNT_WIDTH-1:0] old,
                                                       input logic [CNT_WIDTH-1:0] wd,
                                                       input logic [CNT_WIDTH-1:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    function automatic logic [NUM_CH-1:0] merge_ch(input logic [NUM_CH-1:0] old,
                                                   input logic [NUM_CH-1:0] wd,
                                                   input logic [NUM_CH-1:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    assign wmask  = {{8{s00_axi_wstrb[3]}}, {8{s00_axi_wstrb[2]}},
                     {8{s00_axi_wstrb[1]}}, {8{s00_axi_wstrb[0]}}};
    assign wr_idx = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    // Gating on awready/arready keeps the cycle after an accept from re-accepting
    // the same beat before bvalid/rvalid have risen.
    assign wr_accept = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
    assign rd_accept = s00_axi_arvalid & ~rvalid_q & ~arready_q;
    assign wrap      = run & (cnt_p0 == period_act);

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign PWM_OUT         = pwm_p1;
    assign unused_ok = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0], s00_axi_wdata, wmask};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            run       <= 1'b0;
            ch_en     <= '0;
            period_sh <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
        end else begin
            awready_q <= wr_accept;
            if (awready_q)                      bvalid_q <= 1'b1;
            else if (bvalid_q && s00_axi_bready) bvalid_q <= 1'b0;
            if (wr_accept) begin
                if (wr_idx == A_CTRL && wmask[0]) run <= s00_axi_wdata[0];
                if (wr_idx == A_CH_EN)
                    ch_en <= merge_ch(ch_en, s00_axi_wdata[NUM_CH-1:0], wmask[NUM_CH-1:0]);
                if (wr_idx == A_PERIOD)
                    period_sh <= merge_cnt(period_sh, s00_axi_wdata[CNT_WIDTH-1:0],
                                           wmask[CNT_WIDTH-1:0]);
                for (int i = 0; i < NUM_CH; i++)
                    if (wr_idx == IDX_W'(8 + i))
                        duty_sh[i] <= merge_cnt(duty_sh[i], s00_axi_wdata[CNT_WIDTH-1:0],
                                                wmask[CNT_WIDTH-1:0]);
            end
        end
    end

`ifdef AXI_PWM_IRQ_EN
    logic irq_status, irq_en, irq_q;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            irq_status <= 1'b0;
            irq_en     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            // A wrap in the same cycle as a W1C keeps the status set.
            if (wrap)
                irq_status <= 1'b1;
            else if (wr_accept && wr_idx == A_STAT && wmask[0] && s00_axi_wdata[0])
                irq_status <= 1'b0;
            if (wr_accept && wr_idx == A_IRQEN && wmask[0]) irq_en <= s00_axi_wdata[0];
            irq_q <= irq_status & irq_en;
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        if (rd_idx == A_CTRL)   rd_mux = {31'd0, run};
        if (rd_idx == A_CH_EN)  rd_mux = 32'(ch_en);
        if (rd_idx == A_PERIOD) rd_mux = 32'(period_sh);
        if (rd_idx == A_CNT)    rd_mux = 32'(cnt_p0);
`ifdef AXI_PWM_IRQ_EN
        if (rd_idx == A_STAT)   rd_mux = {31'd0, irq_status};
        if (rd_idx == A_IRQEN)  rd_mux = {31'd0, irq_en};
`endif
        for (int i = 0; i < NUM_CH; i++)
            if (rd_idx == IDX_W'(8 + i)) rd_mux = 32'(duty_sh[i]);
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            arready_q <= rd_accept;
            if (rd_accept) rdata_q <= rd_mux;
            if (arready_q)                       rvalid_q <= 1'b1;
            else if (rvalid_q && s00_axi_rready) rvalid_q <= 1'b0;
        end
    end

    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < NUM_CH; i++)
            pwm_next[i] = run & ch_en[i] & (cnt_p0 < duty_act[i]);
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            cnt_p0     <= '0;
            period_act <= '0;
            pwm_p1     <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
        end else begin
            // stage p0: shared counter and active register set
            if (!run)      cnt_p0 <= '0;
            else if (wrap) cnt_p0 <= '0;
            else           cnt_p0 <= cnt_p0 + 1'b1;
            if (!run || wrap) begin
                period_act <= period_sh;
                for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
            end
            // stage p1: registered compare, one cycle behind the counter
            pwm_p1 <= pwm_next;
        end
    end

endmodule
